// File: rtl/match_run_logger.sv
// match_run_logger: measures contiguous high runs of match_in and queues their lengths in a FIFO
module match_run_logger #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4,
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             match_in,
  input  logic             rd_ready,
  input  logic             clr_ovf,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             run_active,
  output logic [TOT_W-1:0] run_count,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] len, len_nx;
  logic [CNT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic push, pop, accept, drop;
  assign push = (state == RUN) && !match_in;
  assign pop = rd_valid && rd_ready;
  assign accept = push && (cnt != FULL || pop);
  assign drop = push && cnt == FULL && !pop;
  assign rd_valid = cnt != '0;
  assign rd_data = rd_valid ? mem[rd_ptr] : '0;
  assign run_active = state == RUN;
  always_comb begin
    state_nx = match_in ? RUN : IDLE;
    len_nx = !match_in ? len : (state == IDLE) ? CNT_W'(1) : (len == '1) ? len : len + CNT_W'(1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      len <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      run_count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      len <= len_nx;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(accept) - (AW+1)'(pop);
      if (push) run_count <= run_count + TOT_W'(1);
      // a drop at the same edge as a clear keeps the flag set
      if (drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= len;
  end
endmodule

// File: tb/tb_match_run_logger.sv
// tb_match_run_logger: directed stimulus checked against a queue-based run model every cycle
module tb_match_run_logger;
  logic clk = 1'b0;
  logic reset, match_in, rd_ready, clr_ovf;
  logic rd_valid, run_active, overflow;
  logic [7:0] rd_data;
  logic [15:0] run_count;
  int errors = 0;
  int checks = 0;

  match_run_logger #(.CNT_W(8), .DEPTH(4), .TOT_W(16)) dut (
    .clk(clk), .reset(reset), .match_in(match_in), .rd_ready(rd_ready), .clr_ovf(clr_ovf),
    .rd_valid(rd_valid), .rd_data(rd_data), .run_active(run_active),
    .run_count(run_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int q[$];
  int cur = 0;
  bit in_run = 0;
  int total = 0;
  bit ovf = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      cur = 0;
      in_run = 0;
      total = 0;
      ovf = 0;
    end else begin
      if (q.size() > 0 && rd_ready) void'(q.pop_front());
      if (clr_ovf) ovf = 0;
      if (in_run && !match_in) begin
        total = (total + 1) % 65536;
        if (q.size() < 4) q.push_back(cur > 255 ? 255 : cur);
        else ovf = 1;
      end
      cur = match_in ? (in_run ? cur + 1 : 1) : cur;
      in_run = match_in;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("rd_valid", int'(rd_valid), int'(q.size() > 0));
    chk("rd_data", int'(rd_data), q.size() > 0 ? q[0] : 0);
    chk("run_active", int'(run_active), int'(in_run));
    chk("run_count", int'(run_count), total);
    chk("overflow", int'(overflow), int'(ovf));
  end

  task automatic step(input logic m, input logic r, input logic c);
    match_in = m;
    rd_ready = r;
    clr_ovf = c;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step(1, 0, 0);
    step(0, 0, 0);
  endtask

  initial begin
    reset = 0; match_in = 0; rd_ready = 0; clr_ovf = 0;
    repeat (2) @(negedge clk);
    chk("reset rd_valid", int'(rd_valid), 0);
    chk("reset run_count", int'(run_count), 0);
    reset = 1;
    step(1, 0, 0);
    chk("run_active rises", int'(run_active), 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("len3 data", int'(rd_data), 3);
    chk("len3 count", int'(run_count), 1);
    chk("len3 inactive", int'(run_active), 0);
    step(0, 1, 0);
    chk("pop empty valid", int'(rd_valid), 0);
    chk("pop empty data", int'(rd_data), 0);
    run(300);
    chk("saturate", int'(rd_data), 255);
    step(0, 1, 0);
    for (int l = 1; l <= 5; l++) run(l);
    chk("ovf set", int'(overflow), 1);
    chk("ovf count", int'(run_count), 7);
    for (int i = 1; i <= 4; i++) begin
      chk("drain", int'(rd_data), i);
      step(0, 1, 0);
    end
    chk("drained", int'(rd_valid), 0);
    step(0, 0, 1);
    chk("ovf clear", int'(overflow), 0);
    run(7); run(1); run(2); run(3);
    chk("full head", int'(rd_data), 7);
    repeat (9) step(1, 0, 0);
    step(0, 1, 0);
    chk("push+pop full ovf", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      chk("full drain", int'(rd_data), i == 3 ? 9 : i + 1);
      step(0, 1, 0);
    end
    chk("full drained", int'(rd_valid), 0);
    step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    chk("b2b count", int'(run_count), 14);
    chk("b2b first", int'(rd_data), 1);
    step(0, 1, 0);
    chk("b2b second", int'(rd_data), 1);
    step(0, 1, 0);
    repeat (4) run(1);
    step(1, 0, 0);
    step(0, 0, 1);
    chk("drop beats clear", int'(overflow), 1);
    chk("drop count", int'(run_count), 19);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    repeat (10) step(1, 0, 0);
    chk("mid run active", int'(run_active), 1);
    #2 reset = 0;
    #1;
    chk("async rd_valid", int'(rd_valid), 0);
    chk("async rd_data", int'(rd_data), 0);
    chk("async run_active", int'(run_active), 0);
    chk("async run_count", int'(run_count), 0);
    match_in = 0;
    @(negedge clk);
    reset = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("post reset count", int'(run_count), 0);
    chk("post reset valid", int'(rd_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
